// File: rtl/adv7511_init_seq_pkg.sv
// Shared types and table-entry helpers for the ADV7511 register-init sequencer.
package adv7511_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HPD,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [7:0] END_MARKER = 8'hFF;

  localparam int ENTRY_W = 16;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;

  function automatic logic [7:0] entry_reg(input logic [ENTRY_W-1:0] entry);
    return entry[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [7:0] entry_val(input logic [ENTRY_W-1:0] entry);
    return entry[VAL_MSB:VAL_LSB];
  endfunction

  function automatic logic is_end(input logic [ENTRY_W-1:0] entry);
    return entry_reg(entry) == END_MARKER;
  endfunction

endpackage

// File: rtl/adv7511_init_seq_if.sv
// Command/response bus between the init sequencer and the byte-level I2C master.
interface adv7511_init_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_nack;

  // master: the sequencer issuing writes; slave: the I2C engine serving them
  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data,
    input  cmd_ready, rsp_valid, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
    output cmd_ready, rsp_valid, rsp_nack
  );
endinterface

// File: rtl/adv7511_init_seq_hpd_debounce.sv
// Two-flop synchroniser plus stability counter for the raw hot-plug-detect pin.
module hpd_debounce #(
  parameter int HPD_DEBOUNCE = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic hpd,
  output logic level,
  output logic fall
);
  localparam int CW = (HPD_DEBOUNCE > 1) ? $clog2(HPD_DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HPD_DEBOUNCE - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          fall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], hpd};
      fall_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // accepting a new level; it is a fall exactly when the old one was high
        level_reg <= sync_reg[1];
        fall_reg  <= level_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;
endmodule

// File: rtl/adv7511_init_seq.sv
// Walks a register/value table and writes each entry to the ADV7511 over I2C,
// gated on debounced HPD, with per-entry retries and automatic re-run on re-plug.
module adv7511_init_seq
  import adv7511_init_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h39,
  parameter int         NUM_REGS     = 32,
  parameter int         RETRY_MAX    = 3,
  parameter int         HPD_DEBOUNCE = 1000,
  parameter int         RSP_TIMEOUT  = 65535,
  localparam int        IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hpd,
  output logic [IW-1:0]       tbl_addr,
  input  logic [ENTRY_W-1:0]  tbl_data,
  adv7511_init_seq_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IW-1:0]       err_index
);
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RSP_TIMEOUT - 1);

  logic hpd_level;
  logic hpd_fall;

  hpd_debounce #(.HPD_DEBOUNCE(HPD_DEBOUNCE)) u_hpd (
    .clk   (clk),
    .rst   (rst),
    .hpd   (hpd),
    .level (hpd_level),
    .fall  (hpd_fall)
  );

  state_t        state_reg, state_next;
  logic [IW-1:0] index_reg, index_next;
  logic [RW-1:0] retry_reg, retry_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          fetch_phase_reg, fetch_phase_next;
  logic [7:0]    reg_addr_reg, reg_addr_next;
  logic [7:0]    reg_val_reg, reg_val_next;
  logic          cmd_valid_reg, cmd_valid_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          error_reg, error_next;
  logic [IW-1:0] err_index_reg, err_index_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      index_reg       <= '0;
      retry_reg       <= '0;
      tmo_reg         <= '0;
      fetch_phase_reg <= 1'b0;
      reg_addr_reg    <= '0;
      reg_val_reg     <= '0;
      cmd_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      err_index_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      index_reg       <= index_next;
      retry_reg       <= retry_next;
      tmo_reg         <= tmo_next;
      fetch_phase_reg <= fetch_phase_next;
      reg_addr_reg    <= reg_addr_next;
      reg_val_reg     <= reg_val_next;
      cmd_valid_reg   <= cmd_valid_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      error_reg       <= error_next;
      err_index_reg   <= err_index_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    index_next       = index_reg;
    retry_next       = retry_reg;
    tmo_next         = tmo_reg;
    fetch_phase_next = 1'b0;
    reg_addr_next    = reg_addr_reg;
    reg_val_next     = reg_val_reg;
    cmd_valid_next   = 1'b0;
    done_next        = done_reg;
    error_next       = error_reg;
    err_index_next   = err_index_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_WAIT_HPD;
          index_next = '0;
          retry_next = '0;
        end
      end
      ST_WAIT_HPD: begin
        if (hpd_level) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (!hpd_level) begin
          state_next = ST_WAIT_HPD;
          index_next = '0;
          retry_next = '0;
        end else if (!fetch_phase_reg) begin
          // first cycle only presents the address to the external ROM
          fetch_phase_next = 1'b1;
        end else begin
          reg_addr_next = entry_reg(tbl_data);
          reg_val_next  = entry_val(tbl_data);
          if (is_end(tbl_data)) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next     = ST_ISSUE;
            cmd_valid_next = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // a handshake in the same cycle as an HPD drop wins; the response is drained later
        if (bus.cmd_ready) begin
          state_next = ST_WAIT_RSP;
          tmo_next   = '0;
        end else if (!hpd_level) begin
          state_next = ST_WAIT_HPD;
          index_next = '0;
          retry_next = '0;
        end else begin
          cmd_valid_next = 1'b1;
        end
      end
      ST_WAIT_RSP: begin
        tmo_next = tmo_reg + 1'b1;
        if (bus.rsp_valid || (tmo_reg == TMO_LAST)) begin
          if (!hpd_level) begin
            state_next = ST_WAIT_HPD;
            index_next = '0;
            retry_next = '0;
          end else if (bus.rsp_valid && !bus.rsp_nack) begin
            retry_next = '0;
            if (index_reg == IDX_LAST) begin
              index_next = '0;
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              index_next = index_reg + 1'b1;
              state_next = ST_FETCH;
            end
          end else if (retry_reg < RETRY_LIM) begin
            retry_next     = retry_reg + 1'b1;
            state_next     = ST_ISSUE;
            cmd_valid_next = 1'b1;
          end else begin
            err_index_next = index_reg;
            error_next     = 1'b1;
            state_next     = ST_ERROR;
          end
        end
      end
      ST_DONE: begin
        if (hpd_fall || start) begin
          state_next = ST_WAIT_HPD;
          done_next  = 1'b0;
          index_next = '0;
          retry_next = '0;
        end
      end
      ST_ERROR: begin
        if (start) begin
          state_next = ST_WAIT_HPD;
          error_next = 1'b0;
          index_next = '0;
          retry_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE) && (state_next != ST_DONE) && (state_next != ST_ERROR);
  end

  assign tbl_addr      = index_reg;
  assign bus.cmd_valid = cmd_valid_reg;
  assign bus.cmd_dev   = DEV_ADDR;
  assign bus.cmd_reg   = reg_addr_reg;
  assign bus.cmd_data  = reg_val_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign err_index     = err_index_reg;
endmodule
